ysyx_rob: RTL and testbench

// In-order reorder buffer; receiving end of the EXU writeback bundle (dest/result/npc/trap/cause).
// - IDU allocates an entry per dispatched instruction and receives its tag (dest).
// - EXU marks entries complete, out of order, by tag.
// - Entries commit in program order to the regfile/WBU; a commit that mispredicted or trapped raises flush.
// - RS operand lookup (qj/qk) reads completed-but-uncommitted results by tag.

---
 rtl/ysyx_rob.sv | 166 ++++++++++++++++
 tb/tb_ysyx_rob.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rob.sv
// In-order reorder buffer: allocates tags at dispatch, completes entries out of order on
// writeback, retires them in program order and raises flush on a mispredicted or trapping commit.
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_rob #(
   parameter int ROB_SIZE = `YSYX_ROB_SIZE,
   parameter int XLEN     = `YSYX_XLEN,
   localparam int TW      = $clog2(ROB_SIZE) + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            dis_valid,
   output logic            dis_ready,
   input  logic [4:0]      dis_rd,
   input  logic [XLEN-1:0] dis_pc,
   input  logic [XLEN-1:0] dis_pnpc,
   output logic [TW-1:0]   dis_dest,
   input  logic            wb_valid,
   input  logic [TW-1:0]   wb_dest,
   input  logic [XLEN-1:0] wb_result,
   input  logic [XLEN-1:0] wb_npc,
   input  logic            wb_trap,
   input  logic [XLEN-1:0] wb_cause,
   input  logic [TW-1:0]   q_tag,
   output logic            q_ready,
   output logic [XLEN-1:0] q_data,
   output logic            cmt_valid,
   input  logic            cmt_ready,
   output logic [4:0]      cmt_rd,
   output logic [XLEN-1:0] cmt_result,
   output logic [XLEN-1:0] cmt_pc,
   output logic [TW-1:0]   cmt_dest,
   output logic            cmt_trap,
   output logic [XLEN-1:0] cmt_cause,
   output logic            flush,
   output logic [XLEN-1:0] flush_pc
);

   localparam int IW = TW - 1;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_BUSY,
      SLOT_DONE
   } slot_state_e;

   slot_state_e     state_q  [ROB_SIZE];
   slot_state_e     state_n  [ROB_SIZE];
   logic [TW-1:0]   tag_q    [ROB_SIZE];
   logic [4:0]      rd_q     [ROB_SIZE];
   logic [XLEN-1:0] pc_q     [ROB_SIZE];
   logic [XLEN-1:0] pnpc_q   [ROB_SIZE];
   logic [XLEN-1:0] result_q [ROB_SIZE];
   logic [XLEN-1:0] npc_q    [ROB_SIZE];
   logic [XLEN-1:0] cause_q  [ROB_SIZE];
   logic            trap_q   [ROB_SIZE];

   logic [TW-1:0] head_q, tail_q, head_n, tail_n;
   logic [IW-1:0] head_idx, tail_idx, wb_idx, q_idx;
   logic          empty, full, dis_fire, cmt_fire, wb_hit;

   assign head_idx = head_q[IW-1:0];
   assign tail_idx = tail_q[IW-1:0];
   assign wb_idx   = wb_dest[IW-1:0];
   assign q_idx    = q_tag[IW-1:0];

   // Pointers carry a wrap bit so equal indices distinguish full from empty.
   assign empty = (head_q == tail_q);
   assign full  = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

   assign cmt_valid  = !empty && (state_q[head_idx] == SLOT_DONE);
   assign cmt_rd     = rd_q[head_idx];
   assign cmt_result = result_q[head_idx];
   assign cmt_pc     = pc_q[head_idx];
   assign cmt_dest   = head_q;
   assign cmt_trap   = trap_q[head_idx];
   assign cmt_cause  = cause_q[head_idx];
   assign cmt_fire   = cmt_valid && cmt_ready;

   assign flush    = cmt_fire && (trap_q[head_idx] || (npc_q[head_idx] != pnpc_q[head_idx]));
   assign flush_pc = npc_q[head_idx];

   // Space freed by a same-cycle commit is deliberately not reused until next cycle.
   assign dis_ready = !full && !flush;
   assign dis_dest  = tail_q;
   assign dis_fire  = dis_valid && dis_ready;

   // A writeback only lands on a live entry whose full tag matches, filtering stale tags.
   assign wb_hit = wb_valid && (state_q[wb_idx] == SLOT_BUSY) && (tag_q[wb_idx] == wb_dest);

   // Operand lookup forwards a same-cycle writeback ahead of the stored result.
   always_comb begin
      q_ready = 1'b0;
      q_data  = result_q[q_idx];
      if (wb_valid && (wb_dest == q_tag)) begin
         q_ready = 1'b1;
         q_data  = wb_result;
      end else if ((tag_q[q_idx] == q_tag) && (state_q[q_idx] == SLOT_DONE)) begin
         q_ready = 1'b1;
      end
   end

   // Slot state and pointer updates; a flush wins over every other event in the cycle.
   always_comb begin
      state_n = state_q;
      head_n  = head_q;
      tail_n  = tail_q;
      if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            state_n[i] = SLOT_FREE;
         end
         head_n = '0;
         tail_n = '0;
      end else begin
         if (dis_fire) begin
            state_n[tail_idx] = SLOT_BUSY;
            tail_n            = tail_q + TW'(1);
         end
         if (wb_hit) begin
            state_n[wb_idx] = SLOT_DONE;
         end
         if (cmt_fire) begin
            state_n[head_idx] = SLOT_FREE;
            head_n            = head_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            state_q[i] <= SLOT_FREE;
         end
         head_q <= '0;
         tail_q <= '0;
      end else begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            state_q[i] <= state_n[i];
         end
         head_q <= head_n;
         tail_q <= tail_n;
      end
   end

   // Payload is only meaningful while its slot is BUSY/DONE, so it needs no reset.
   always_ff @(posedge clock) begin
      if (reset && dis_fire) begin
         tag_q[tail_idx]  <= tail_q;
         rd_q[tail_idx]   <= dis_rd;
         pc_q[tail_idx]   <= dis_pc;
         pnpc_q[tail_idx] <= dis_pnpc;
      end
      if (reset && wb_hit && !flush) begin
         result_q[wb_idx] <= wb_result;
         npc_q[wb_idx]    <= wb_npc;
         trap_q[wb_idx]   <= wb_trap;
         cause_q[wb_idx]  <= wb_cause;
      end
   end

endmodule

// File: tb/tb_ysyx_rob.sv
// Self-checking bench for ysyx_rob: directed vector table, hand-written corner sequences,
// then randomized traffic checked every cycle against a queue-based model of the buffer.
module tb_ysyx_rob;

   localparam int ROB_SIZE = 4;
   localparam int XLEN     = 32;
   localparam int TW       = 3;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            dis_valid, dis_ready;
   logic [4:0]      dis_rd;
   logic [XLEN-1:0] dis_pc, dis_pnpc;
   logic [TW-1:0]   dis_dest;
   logic            wb_valid;
   logic [TW-1:0]   wb_dest;
   logic [XLEN-1:0] wb_result, wb_npc, wb_cause;
   logic            wb_trap;
   logic [TW-1:0]   q_tag;
   logic            q_ready;
   logic [XLEN-1:0] q_data;
   logic            cmt_valid, cmt_ready;
   logic [4:0]      cmt_rd;
   logic [XLEN-1:0] cmt_result, cmt_pc, cmt_cause;
   logic [TW-1:0]   cmt_dest;
   logic            cmt_trap;
   logic            flush;
   logic [XLEN-1:0] flush_pc;

   always #5 clock = ~clock;

   ysyx_rob #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset),
      .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_rd(dis_rd), .dis_pc(dis_pc),
      .dis_pnpc(dis_pnpc), .dis_dest(dis_dest),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
      .wb_trap(wb_trap), .wb_cause(wb_cause),
      .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_rd(cmt_rd), .cmt_result(cmt_result),
      .cmt_pc(cmt_pc), .cmt_dest(cmt_dest), .cmt_trap(cmt_trap), .cmt_cause(cmt_cause),
      .flush(flush), .flush_pc(flush_pc)
   );

   // Reference model: in-flight instructions in program order, oldest at index 0.
   typedef struct {
      int              tag;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc, pnpc, result, npc, cause;
      bit              trap;
      bit              done;
   } ent_t;

   ent_t rob[$];
   int   next_tag = 0;
   int   nvec = 0;
   int   nmis = 0;

   typedef struct {
      bit              dv;
      bit              wv;
      logic [TW-1:0]   wd;
      logic [XLEN-1:0] wr;
      bit              cr;
      logic [TW-1:0]   qt;
      bit              e_dr;
      logic [TW-1:0]   e_dd;
      bit              e_cv;
      logic [TW-1:0]   e_cd;
      logic [XLEN-1:0] e_cres;
      bit              e_qr;
      logic [XLEN-1:0] e_qd;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(int dv, int wv, int wd, int wr, int cr, int qt, int edr, int edd,
                               int ecv, int ecd, int ecres, int eqr, int eqd);
      vec_t v;
      v.dv = (dv != 0);  v.wv = (wv != 0);  v.wd = TW'(wd);  v.wr = XLEN'(wr);
      v.cr = (cr != 0);  v.qt = TW'(qt);    v.e_dr = (edr != 0);  v.e_dd = TW'(edd);
      v.e_cv = (ecv != 0);  v.e_cd = TW'(ecd);  v.e_cres = XLEN'(ecres);
      v.e_qr = (eqr != 0);  v.e_qd = XLEN'(eqd);
      return v;
   endfunction

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      dis_valid = 1'b0;  dis_rd = '0;  dis_pc = '0;  dis_pnpc = '0;
      wb_valid = 1'b0;  wb_dest = '0;  wb_result = '0;  wb_npc = '0;  wb_trap = 1'b0;  wb_cause = '0;
      cmt_ready = 1'b0;  q_tag = '0;
   endtask

   // One clock cycle: compare every output against the model, then advance model and DUT together.
   task automatic tick();
      bit              rst_n, cv, fl, dr, qr;
      logic [XLEN-1:0] qd;
      bit              dv, wv, wt, cr;
      logic [TW-1:0]   wd;
      logic [4:0]      drd;
      logic [XLEN-1:0] dpc, dpn, wr, wn, wc;
      @(negedge clock);
      rst_n = reset;
      cv = (rob.size() > 0) && rob[0].done;
      fl = cv && cmt_ready && (rob[0].trap || (rob[0].npc != rob[0].pnpc));
      dr = (rob.size() < ROB_SIZE) && !fl;
      qr = 1'b0;
      qd = '0;
      if (wb_valid && (int'(wb_dest) == int'(q_tag))) begin
         qr = 1'b1;
         qd = wb_result;
      end else begin
         foreach (rob[i]) begin
            if (rob[i].tag == int'(q_tag) && rob[i].done) begin
               qr = 1'b1;
               qd = rob[i].result;
            end
         end
      end
      if (rst_n) begin
         check("m_dis_ready", dis_ready, dr);
         check("m_dis_dest", dis_dest, XLEN'(next_tag));
         check("m_cmt_valid", cmt_valid, cv);
         check("m_flush", flush, fl);
         check("m_q_ready", q_ready, qr);
         if (qr) check("m_q_data", q_data, qd);
         if (cv) begin
            check("m_cmt_dest", cmt_dest, XLEN'(rob[0].tag));
            check("m_cmt_rd", cmt_rd, rob[0].rd);
            check("m_cmt_pc", cmt_pc, rob[0].pc);
            check("m_cmt_result", cmt_result, rob[0].result);
            check("m_cmt_trap", cmt_trap, rob[0].trap);
            if (rob[0].trap) check("m_cmt_cause", cmt_cause, rob[0].cause);
         end
         if (fl) check("m_flush_pc", flush_pc, rob[0].npc);
      end
      dv = dis_valid;  drd = dis_rd;  dpc = dis_pc;  dpn = dis_pnpc;
      wv = wb_valid;  wd = wb_dest;  wr = wb_result;  wn = wb_npc;  wt = wb_trap;  wc = wb_cause;
      cr = cmt_ready;
      @(posedge clock);
      if (!rst_n || fl) begin
         rob.delete();
         next_tag = 0;
      end else begin
         if (wv) begin
            foreach (rob[i]) begin
               if (rob[i].tag == int'(wd) && !rob[i].done) begin
                  rob[i].done = 1'b1;  rob[i].result = wr;  rob[i].npc = wn;
                  rob[i].trap = wt;    rob[i].cause = wc;
               end
            end
         end
         if (cv && cr) void'(rob.pop_front());
         if (dv && dr) begin
            ent_t e;
            e.tag = next_tag;  e.rd = drd;  e.pc = dpc;  e.pnpc = dpn;
            e.result = '0;  e.npc = '0;  e.cause = '0;  e.trap = 1'b0;  e.done = 1'b0;
            rob.push_back(e);
            next_tag = (next_tag + 1) % (2 * ROB_SIZE);
         end
      end
      #1;
   endtask

   task automatic dispatch(input int rd, input logic [XLEN-1:0] pnpc);
      idle();
      dis_valid = 1'b1;  dis_rd = 5'(rd);  dis_pc = pnpc - 32'd4;  dis_pnpc = pnpc;
   endtask

   task automatic writeback(input int tag, input logic [XLEN-1:0] res, input logic [XLEN-1:0] npc);
      idle();
      wb_valid = 1'b1;  wb_dest = TW'(tag);  wb_result = res;  wb_npc = npc;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;

      // Fill, overflow attempt, out-of-order completion, in-order retirement.
      tbl[0]  = mk(1, 0, 0, 0,     0, 7, 1, 0, 0, 0, 0,     0, 0);
      tbl[1]  = mk(1, 0, 0, 0,     0, 7, 1, 1, 0, 0, 0,     0, 0);
      tbl[2]  = mk(1, 0, 0, 0,     0, 7, 1, 2, 0, 0, 0,     0, 0);
      tbl[3]  = mk(1, 0, 0, 0,     0, 7, 1, 3, 0, 0, 0,     0, 0);
      tbl[4]  = mk(1, 0, 0, 0,     0, 7, 0, 4, 0, 0, 0,     0, 0);
      tbl[5]  = mk(0, 1, 2, 'h22,  0, 2, 0, 4, 0, 0, 0,     1, 'h22);
      tbl[6]  = mk(0, 1, 1, 'h11,  0, 2, 0, 4, 0, 0, 0,     1, 'h22);
      tbl[7]  = mk(0, 1, 0, 'h00,  1, 0, 0, 4, 0, 0, 0,     1, 'h00);
      tbl[8]  = mk(0, 0, 0, 0,     1, 0, 0, 4, 1, 0, 'h00,  1, 'h00);
      tbl[9]  = mk(0, 0, 0, 0,     1, 3, 1, 4, 1, 1, 'h11,  0, 0);
      tbl[10] = mk(0, 0, 0, 0,     1, 3, 1, 4, 1, 2, 'h22,  0, 0);
      tbl[11] = mk(0, 0, 0, 0,     1, 3, 1, 4, 0, 0, 0,     0, 0);
      for (int r = 0; r < 12; r++) begin
         idle();
         dis_valid = tbl[r].dv;  dis_rd = 5'(r + 1);  dis_pc = 32'h8000_0000;  dis_pnpc = 32'h8000_0004;
         wb_valid = tbl[r].wv;  wb_dest = tbl[r].wd;  wb_result = tbl[r].wr;  wb_npc = 32'h8000_0004;
         cmt_ready = tbl[r].cr;  q_tag = tbl[r].qt;
         #2;
         check($sformatf("tbl%0d_dis_ready", r), dis_ready, tbl[r].e_dr);
         check($sformatf("tbl%0d_dis_dest", r), dis_dest, tbl[r].e_dd);
         check($sformatf("tbl%0d_cmt_valid", r), cmt_valid, tbl[r].e_cv);
         if (tbl[r].e_cv) begin
            check($sformatf("tbl%0d_cmt_dest", r), cmt_dest, tbl[r].e_cd);
            check($sformatf("tbl%0d_cmt_result", r), cmt_result, tbl[r].e_cres);
         end
         check($sformatf("tbl%0d_q_ready", r), q_ready, tbl[r].e_qr);
         if (tbl[r].e_qr) check($sformatf("tbl%0d_q_data", r), q_data, tbl[r].e_qd);
         tick();
      end

      // Reset with a live entry and competing dispatch/writeback: everything is discarded.
      idle();
      reset = 1'b0;  dis_valid = 1'b1;  wb_valid = 1'b1;  wb_dest = 3'd3;  wb_npc = 32'h8000_0004;
      tick();
      reset = 1'b1;
      idle();
      q_tag = 3'd3;
      #2;
      check("rst_dis_dest", dis_dest, 0);
      check("rst_dis_ready", dis_ready, 1);
      check("rst_cmt_valid", cmt_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_q_ready", q_ready, 0);
      tick();

      // Pointer wrap, with a stale-tag writeback aimed at the reused slot.
      for (int i = 0; i < 6; i++) begin
         dispatch(i + 1, 32'h8000_0004);
         #2;
         check($sformatf("wrap%0d_dis_dest", i), dis_dest, XLEN'(i));
         tick();
         if (i == 4) begin
            writeback(0, 32'hdead, 32'h8000_0004);
            tick();
            idle();
            q_tag = 3'd4;
            #2;
            check("stale_cmt_valid", cmt_valid, 0);
            check("stale_q_ready", q_ready, 0);
            tick();
         end
         writeback(i, XLEN'(16 * i + 5), 32'h8000_0004);
         tick();
         idle();
         cmt_ready = 1'b1;
         #2;
         check($sformatf("wrap%0d_cmt_valid", i), cmt_valid, 1);
         check($sformatf("wrap%0d_cmt_dest", i), cmt_dest, XLEN'(i));
         check($sformatf("wrap%0d_cmt_result", i), cmt_result, XLEN'(16 * i + 5));
         tick();
      end

      // Mispredict: commit redirects, drops a younger writeback and a same-cycle dispatch.
      dispatch(3, 32'h8000_0008);
      tick();
      dispatch(4, 32'h8000_000c);
      tick();
      writeback(6, 32'h1, 32'h8000_0020);
      tick();
      writeback(7, 32'h2, 32'h8000_000c);
      cmt_ready = 1'b1;  dis_valid = 1'b1;  dis_pnpc = 32'h8000_0010;
      #2;
      check("mp_cmt_valid", cmt_valid, 1);
      check("mp_flush", flush, 1);
      check("mp_flush_pc", flush_pc, 32'h8000_0020);
      check("mp_dis_ready", dis_ready, 0);
      tick();
      idle();
      q_tag = 3'd7;
      #2;
      check("mp_after_cmt_valid", cmt_valid, 0);
      check("mp_after_dis_dest", dis_dest, 0);
      check("mp_after_dis_ready", dis_ready, 1);
      check("mp_after_q_ready", q_ready, 0);
      tick();

      // Trap commit.
      dispatch(9, 32'h8000_0104);
      tick();
      writeback(0, 32'h0, 32'h8000_0104);
      wb_trap = 1'b1;  wb_cause = 32'd2;
      tick();
      idle();
      cmt_ready = 1'b1;
      #2;
      check("trap_cmt_valid", cmt_valid, 1);
      check("trap_cmt_trap", cmt_trap, 1);
      check("trap_cmt_cause", cmt_cause, 2);
      check("trap_flush", flush, 1);
      tick();

      // Operand lookup: bypass of a same-cycle writeback, then a still-busy entry.
      dispatch(1, 32'h8000_0204);
      tick();
      dispatch(2, 32'h8000_0208);
      tick();
      writeback(1, 32'hab, 32'h8000_0208);
      q_tag = 3'd1;
      #2;
      check("lk_bypass_ready", q_ready, 1);
      check("lk_bypass_data", q_data, 32'hab);
      tick();
      idle();
      q_tag = 3'd0;
      #2;
      check("lk_busy_ready", q_ready, 0);
      tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         int undone[$];
         idle();
         reset = ($urandom_range(0, 199) != 0);
         dis_valid = ($urandom_range(0, 3) != 0);
         dis_rd = 5'($urandom);
         dis_pc = $urandom;
         dis_pnpc = dis_pc + 32'd4;
         foreach (rob[i]) if (!rob[i].done) undone.push_back(i);
         if (undone.size() > 0 && $urandom_range(0, 2) != 0) begin
            int k;
            k = undone[$urandom_range(0, undone.size() - 1)];
            wb_valid = 1'b1;
            wb_dest = TW'(rob[k].tag);
            wb_result = $urandom;
            wb_npc = ($urandom_range(0, 9) == 0) ? (rob[k].pnpc ^ 32'h10) : rob[k].pnpc;
            wb_trap = ($urandom_range(0, 19) == 0);
            wb_cause = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            wb_valid = 1'b1;
            wb_dest = TW'($urandom);
            wb_result = $urandom;
            wb_npc = $urandom;
         end
         cmt_ready = ($urandom_range(0, 2) != 0);
         q_tag = TW'($urandom);
         tick();
      end
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
